// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared constants and FSM encoding for the multiply/divide unit
//
// Purpose: FSM state encoding, default operand width and the MULT/DIV funct
// codes shared with the multicycle control unit.
// Ports: none (package).
package mult_div_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // funct field values decoded by the control unit to raise MULT_control / DIV_control
  localparam logic [5:0] FUNCT_MULT = 6'd24;
  localparam logic [5:0] FUNCT_DIV  = 6'd26;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MULT_RUN = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// rtl/mult_div_unit_booth_step.sv - one radix-2 Booth iteration (combinational)
//
// Purpose: given the {upper, lower, q(-1)} accumulator and the multiplicand,
// add/subtract the multiplicand into the upper half as selected by the two
// low accumulator bits, then arithmetic-shift the whole accumulator right.
// Ports:
//   acc_i   [2*WIDTH:0]  current accumulator
//   mcand_i [WIDTH-1:0]  signed multiplicand
//   acc_o   [2*WIDTH:0]  accumulator after this step
module mult_div_unit_booth_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0] upper_ext;
  logic [WIDTH:0] mcand_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    // One guard bit on the add keeps the sign correct when the multiplicand
    // is the most negative value; the guard bit becomes the shifted-in MSB.
    upper_ext = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand_i[WIDTH-1], mcand_i};
    case (acc_i[1:0])
      2'b01:   sum = upper_ext + mcand_ext;
      2'b10:   sum = upper_ext - mcand_ext;
      default: sum = upper_ext;
    endcase
    acc_o = {sum, acc_i[WIDTH:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply/divide unit, one bit per clock
//
// Purpose: serves MULT and DIV for the multicycle control unit. Multiply is
// radix-2 Booth over WIDTH cycles; divide is restoring division on magnitudes
// over WIDTH cycles followed by a sign-fix cycle. Results land in HI/LO on
// the edge entering DONE, together with a one-cycle stop pulse.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   MULT_control          start signed multiply (sampled only in IDLE, wins over DIV)
//   DIV_control           start signed divide (sampled only in IDLE)
//   A, B                  multiplicand/dividend, multiplier/divisor
//   HI, LO                product high/low, or remainder/quotient
//   multStop, divStop     one-cycle completion pulses
//   divZero               one-cycle pulse with divStop when the divisor was 0
//   busy                  operation in flight
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MULT_control,
  input  logic             DIV_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             multStop,
  output logic             divStop,
  output logic             divZero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             mult_stop_q, mult_stop_d;
  logic             div_stop_q, div_stop_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;

  logic [AW-1:0]    booth_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  mult_div_unit_booth_step #(
    .WIDTH(WIDTH)
  ) u_booth_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .acc_o  (booth_next)
  );

  // Restoring step: shift the next dividend bit into the partial remainder
  // and trial-subtract the divisor; a clear sign bit means the subtract fits.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (MULT_control) begin
          state_d = ST_MULT_RUN;
        end else if (DIV_control) begin
          // Divide-by-zero still passes through DIV_FIX so it reports one
          // edge after the start is taken.
          state_d = (B == '0) ? ST_DIV_FIX : ST_DIV_RUN;
        end
      end
      ST_MULT_RUN: if (cnt_q == '0) state_d = ST_DONE;
      ST_DIV_RUN:  if (cnt_q == '0) state_d = ST_DIV_FIX;
      ST_DIV_FIX:  state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    dz_d        = dz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mult_stop_d = 1'b0;
    div_stop_d  = 1'b0;
    div_zero_d  = 1'b0;
    busy_d      = (state_d == ST_MULT_RUN) || (state_d == ST_DIV_RUN) ||
                  (state_d == ST_DIV_FIX);

    case (state_q)
      ST_IDLE: begin
        if (MULT_control) begin
          mcand_d = A;
          acc_d   = {{WIDTH{1'b0}}, B, 1'b0};
          cnt_d   = CW'(WIDTH);
        end else if (DIV_control) begin
          if (B == '0) begin
            dz_d = 1'b1;
          end else begin
            dz_d      = 1'b0;
            rem_d     = '0;
            quo_d     = A[WIDTH-1] ? -A : A;
            dvs_d     = B[WIDTH-1] ? -B : B;
            quo_neg_d = A[WIDTH-1] ^ B[WIDTH-1];
            rem_neg_d = A[WIDTH-1];
            cnt_d     = CW'(WIDTH);
          end
        end
      end

      ST_MULT_RUN: begin
        if (cnt_q != '0) begin
          acc_d = booth_next;
          cnt_d = cnt_q - CW'(1);
        end else begin
          hi_d        = acc_q[AW-1:WIDTH+1];
          lo_d        = acc_q[WIDTH:1];
          mult_stop_d = 1'b1;
        end
      end

      ST_DIV_RUN: begin
        if (cnt_q != '0) begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DIV_FIX: begin
        div_stop_d = 1'b1;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend.
          lo_d = quo_neg_q ? -quo_q : quo_q;
          hi_d = rem_neg_q ? -rem_q : rem_q;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      mult_stop_q <= 1'b0;
      div_stop_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      dz_q        <= dz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mult_stop_q <= mult_stop_d;
      div_stop_q  <= div_stop_d;
      div_zero_q  <= div_zero_d;
      busy_q      <= busy_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign multStop = mult_stop_q;
  assign divStop  = div_stop_q;
  assign divZero  = div_zero_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        MULT_control;
  logic        DIV_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        multStop;
  logic        divStop;
  logic        divZero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // results of the most recent run_op
  int   lat;
  logic saw_mult, saw_div, saw_zero, busy_first;
  int   stray;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .MULT_control(MULT_control),
    .DIV_control (DIV_control),
    .A           (A),
    .B           (B),
    .HI          (HI),
    .LO          (LO),
    .multStop    (multStop),
    .divStop     (divStop),
    .divZero     (divZero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives the start for one cycle, scrambles A/B after
  // the start edge, optionally pulses DIV_control at cycle 'inject', and
  // returns at the negedge where a stop pulse is first seen (or on timeout).
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input int inject);
    int n;
    MULT_control = m;
    DIV_control  = d;
    A = a;
    B = b;
    n = 0;
    lat = -1;
    saw_mult = 1'b0;
    saw_div = 1'b0;
    saw_zero = 1'b0;
    busy_first = 1'b0;
    while (n < 80 && lat < 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      MULT_control = 1'b0;
      DIV_control  = (n == inject);
      A = 32'h1234_5678;
      B = 32'h0;
      if (n == 1) busy_first = busy;
      if (multStop || divStop) begin
        lat = n - 1;
        saw_mult = multStop;
        saw_div = divStop;
        saw_zero = divZero;
      end
    end
    DIV_control = 1'b0;
  endtask

  // One cycle after the stop: pulse gone, unit idle.
  task automatic chk_after(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_stop_low"}, {30'd0, multStop, divStop}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic count_stray(input int cycles);
    stray = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (multStop || divStop || divZero) stray++;
    end
  endtask

  initial begin
    reset = 1'b1;
    MULT_control = 1'b0;
    DIV_control = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_flags", {28'd0, multStop, divStop, divZero, busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 7 * -3 = -21
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    chk("m1_lat", 32'(lat), 32'd33);
    chk("m1_kind", {29'd0, saw_mult, saw_div, saw_zero}, 32'b100);
    chk("m1_busy", {31'd0, busy_first}, 32'd1);
    chk("m1_hi", HI, 32'hFFFF_FFFF);
    chk("m1_lo", LO, 32'hFFFF_FFEB);
    chk_after("m1");

    // (2^31-1)^2 = 0x3FFFFFFF_00000001
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    chk("m2_hi", HI, 32'h3FFF_FFFF);
    chk("m2_lo", LO, 32'h0000_0001);
    chk_after("m2");

    // (-2^31)^2 = 2^62
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    chk("m3_hi", HI, 32'h4000_0000);
    chk("m3_lo", LO, 32'h0000_0000);
    chk_after("m3");

    // -7 / 2 = -3 rem -1
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    chk("d1_lat", 32'(lat), 32'd34);
    chk("d1_kind", {29'd0, saw_mult, saw_div, saw_zero}, 32'b010);
    chk("d1_busy", {31'd0, busy_first}, 32'd1);
    chk("d1_lo", LO, 32'hFFFF_FFFD);
    chk("d1_hi", HI, 32'hFFFF_FFFF);
    chk_after("d1");

    // -2^31 / -1 = 0x80000000 rem 0, no flag
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("d2_kind", {29'd0, saw_mult, saw_div, saw_zero}, 32'b010);
    chk("d2_lo", LO, 32'h8000_0000);
    chk("d2_hi", HI, 32'h0);
    chk_after("d2");

    // 5 / 0: flag after one edge, HI/LO untouched
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_kind", {29'd0, saw_mult, saw_div, saw_zero}, 32'b011);
    chk("dz_lo", LO, 32'h8000_0000);
    chk("dz_hi", HI, 32'h0);
    chk_after("dz");

    // 100 / -7 = -14 rem 2
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0);
    chk("d3_lo", LO, 32'hFFFF_FFF2);
    chk("d3_hi", HI, 32'd2);
    chk_after("d3");

    // -100 / -7 = 14 rem -2
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0);
    chk("d4_lo", LO, 32'd14);
    chk("d4_hi", HI, 32'hFFFF_FFFE);
    chk_after("d4");

    // both starts: MULT wins; stray DIV pulse mid-run ignored
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 5);
    chk("both_kind", {29'd0, saw_mult, saw_div, saw_zero}, 32'b100);
    chk("both_lat", 32'(lat), 32'd33);
    chk("both_lo", LO, 32'd12);
    chk("both_hi", HI, 32'd0);
    count_stray(40);
    chk("both_no_extra", 32'(stray), 32'd0);

    // back-to-back: start in DONE ignored, start in first IDLE accepted
    run_op(1'b1, 1'b0, 32'd9, 32'd9, 0);
    chk("b2b_first_lo", LO, 32'd81);
    MULT_control = 1'b1;
    A = 32'd2;
    B = 32'd3;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done_ignored", {31'd0, busy}, 32'd0);
    run_op(1'b1, 1'b0, 32'd2, 32'd3, 0);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_lo", LO, 32'd6);
    chk_after("b2b");

    // asynchronous reset mid-multiply
    MULT_control = 1'b1;
    A = 32'd5;
    B = 32'd6;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      MULT_control = 1'b0;
    end
    chk("ar_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_hi", HI, 32'h0);
    chk("ar_lo", LO, 32'h0);
    chk("ar_flags", {28'd0, multStop, divStop, divZero, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_stray(40);
    chk("ar_no_stop", 32'(stray), 32'd0);
    run_op(1'b1, 1'b0, 32'd5, 32'd6, 0);
    chk("ar_new_lat", 32'(lat), 32'd33);
    chk("ar_new_lo", LO, 32'd30);
    chk("ar_new_hi", HI, 32'd0);
    chk_after("ar_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit serving the multicycle control unit's MULT and DIV instructions.
- Takes a one-cycle start (MULT_control or DIV_control) with operands from the A/B registers and iterates one bit per clock.
- Writes HI/LO and returns the multStop/divStop completion handshake the control unit waits on; flags divide-by-zero for the exception path.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MULT_control  input  1  start signed multiply; sampled only in IDLE.
- DIV_control  input  1  start signed divide; sampled only in IDLE.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- HI  output  WIDTH  product upper half / remainder.
- LO  output  WIDTH  product lower half / quotient.
- multStop  output  1  one-cycle pulse: multiply result valid on HI/LO.
- divStop  output  1  one-cycle pulse: divide finished (result or div-by-zero).
- divZero  output  1  one-cycle pulse coincident with divStop when B was 0.
- busy  output  1  high from the edge after start until the edge that raises the stop pulse.

Behaviour:
- Reset (async, active-high): state IDLE; HI=0, LO=0, multStop=0, divStop=0, divZero=0, busy=0; internal counters and accumulators cleared. Reset mid-operation aborts with no stop pulse.
- FSM states: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE:
  - MULT_control=1 -> latch A, B; go to MULT_RUN; counter=WIDTH.
  - Else DIV_control=1 with B!=0 -> latch |A|, |B| and the signs; go to DIV_RUN.
  - Else DIV_control=1 with B==0 -> go to DONE with divStop=1 and divZero=1 in the next cycle; HI/LO unchanged.
  - Both starts high -> MULT wins; DIV ignored.
- Starts asserted while not in IDLE are ignored; no queuing.
- MULT_RUN: radix-2 Booth, 2*WIDTH+1-bit accumulator, arithmetic shift right each cycle, WIDTH cycles; then DONE.
- DIV_RUN: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles; then DIV_FIX.
- DIV_FIX (1 cycle): apply signs.
  - Quotient negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
- DONE (1 cycle):
  - HI/LO registered on the edge entering DONE; the matching stop pulse is high for exactly this cycle; next state IDLE.
  - HI/LO hold until the next successful completion.
- Latency, start sampled at edge k:
  - multiply: multStop high for the cycle after edge k+WIDTH+1 (k+33).
  - divide: divStop high for the cycle after edge k+WIDTH+2 (k+34).
  - divide-by-zero: divStop/divZero high for the cycle after edge k+1.
- Back-to-back: a start presented in the DONE cycle is ignored; a start is accepted in the first IDLE cycle.
- Arithmetic edge cases:
  - -2^(WIDTH-1) / -1 gives LO=0x80000000, HI=0; no flag.
  - Multiply never overflows; the full 64-bit product is kept.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - FSM state encodings (IDLE..DONE).
  - WIDTH default.
  - Opcode/funct constants MULT=6'd24 and DIV=6'd26, shared with the control unit.
- No sub-module is required. An optional booth_step combinational helper may be factored out; the divider step stays inline.

Test Plan:
- MULT A=7, B=-3 -> multStop pulse 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy low afterwards.
- MULT A=0x7FFFFFFF, B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
- DIV A=-7, B=2 -> divStop pulse at 34 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divZero=0. Then DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- DIV A=5, B=0 -> divStop=divZero=1 one cycle after start; HI/LO keep their prior values.
- MULT_control and DIV_control high together with A=3, B=4 -> only multStop; LO=12. A DIV_control pulse mid-run is ignored, with no extra divStop.
- Assert reset at cycle 10 of a MULT -> all outputs 0 immediately (asynchronous); no multStop; a new MULT after reset release completes normally.
